// File: rtl/instruction_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch front end: opcode class patterns that
// decide instruction length, and the longest instruction in bytes.
package instruction_fetch_unit_pkg;

    localparam int unsigned INSTR_MAX_BYTES = 2;

    localparam logic [7:0] OP_JUD = 8'h03;
    localparam logic [7:0] OP_CUD = 8'h05;

    // Groups selected by opcode[7:3]
    localparam logic [4:0] GRP_JCD = 5'b00001;
    localparam logic [4:0] GRP_CCD = 5'b00110;
    localparam logic [4:0] GRP_MVI = 5'b01011;

    // ALU-immediate is 1xxx_1xxx, but OUT (1111_1xxx) takes no operand
    localparam logic [7:0] ALU_IMM_MASK = 8'h88;
    localparam logic [7:0] ALU_IMM_VAL  = 8'h88;
    localparam logic [7:0] OUT_MASK     = 8'hF8;
    localparam logic [7:0] OUT_VAL      = 8'hF8;

endpackage

// File: rtl/instr_length_decode.sv
// Combinational opcode length decode: flags opcodes that carry an operand byte.
// Every one of the 256 opcodes decodes to a length; none are rejected.
module instr_length_decode
    import instruction_fetch_unit_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       is_two_byte
);

    logic alu_imm;

    always_comb begin
        alu_imm     = ((opcode & ALU_IMM_MASK) == ALU_IMM_VAL) &&
                      ((opcode & OUT_MASK) != OUT_VAL);
        is_two_byte = (opcode == OP_JUD) || (opcode == OP_CUD) ||
                      (opcode[7:3] == GRP_JCD) || (opcode[7:3] == GRP_CCD) ||
                      (opcode[7:3] == GRP_MVI) || alu_imm;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: prefetches program bytes into a circular byte queue and
// issues whole one- or two-byte instructions through a registered output stage.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              instr_valid,
    output logic [7:0]        opcode,
    output logic [7:0]        operand,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_len2
);

    localparam int unsigned       PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [7:0]        queue_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] fetch_pc_q, head_pc_q;

    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  need_n, pop_n;
    logic              push, slot_free, head_complete, head_len2;
    logic [7:0]        head_byte, next_byte;

    assign head_byte = queue_q[head_q];
    assign next_byte = queue_q[head_q + PTR_W'(1)];

    instr_length_decode u_len_decode (
        .opcode      (head_byte),
        .is_two_byte (head_len2)
    );

    always_comb begin
        // Reserve a slot for the read in flight so a returning byte always fits
        occupancy     = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        mem_rd_en     = !reset && !redirect && (occupancy < DEPTH_OCC);
        mem_addr      = fetch_pc_q;
        push          = inflight_q && !redirect;
        need_n        = head_len2 ? CNT_W'(INSTR_MAX_BYTES) : CNT_W'(1);
        head_complete = count_q >= need_n;
        slot_free     = !instr_valid || !stall;
        pop_n         = (slot_free && head_complete && !redirect) ? need_n : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            fetch_pc_q  <= RESET_ADDR;
            head_pc_q   <= RESET_ADDR;
            instr_valid <= 1'b0;
            opcode      <= '0;
            operand     <= '0;
            instr_pc    <= '0;
            instr_len2  <= 1'b0;
        end else if (redirect) begin
            // Flush; clearing inflight_q drops the byte of any read already issued
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            fetch_pc_q  <= redirect_pc;
            head_pc_q   <= redirect_pc;
            instr_valid <= 1'b0;
        end else begin
            inflight_q <= mem_rd_en;
            if (mem_rd_en) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            count_q   <= count_q + CNT_W'(push) - pop_n;
            head_q    <= head_q + PTR_W'(pop_n);
            head_pc_q <= head_pc_q + ADDR_W'(pop_n);
            if (slot_free) begin
                instr_valid <= head_complete;
                if (head_complete) begin
                    opcode     <= head_byte;
                    operand    <= head_len2 ? next_byte : 8'h00;
                    instr_pc   <= head_pc_q;
                    instr_len2 <= head_len2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[tail_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: synchronous ROM model plus a
// reference that walks the program image using the opcode length rules.
module tb_instruction_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       stall = 1'b0;
    logic       instr_valid;
    logic [7:0] opcode, operand, instr_pc;
    logic       instr_len2;

    logic [7:0] rom [256];
    int         reads;
    int         tests = 0;
    int         fails = 0;

    instruction_fetch_unit #(
        .ADDR_W      (8),
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .instr_pc    (instr_pc),
        .instr_len2  (instr_len2)
    );

    always #5 clk = ~clk;

    // Synchronous program memory; also counts reads issued since reset/redirect
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            reads    <= 0;
            mem_data <= 8'h00;
        end else if (mem_rd_en) begin
            mem_data <= rom[mem_addr];
            reads    <= reads + 1;
        end else if (redirect) begin
            reads <= 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    function automatic bit ref_len2(input logic [7:0] op);
        logic [4:0] grp;
        grp = op[7:3];
        if (op == 8'h03 || op == 8'h05) return 1'b1;
        if (grp == 5'b00001 || grp == 5'b00110 || grp == 5'b01011) return 1'b1;
        if (grp == 5'b11111) return 1'b0;
        return op[7] && op[3];
    endfunction

    // {opcode, operand, len2} expected for the instruction starting at pc
    function automatic logic [16:0] ref_instr(input logic [7:0] pc);
        logic [7:0] pc1;
        logic [7:0] op;
        pc1 = pc + 8'd1;
        op  = rom[pc];
        return {op, ref_len2(op) ? rom[pc1] : 8'h00, ref_len2(op)};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({mem_rd_en, instr_valid, opcode, operand, instr_pc, instr_len2} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {mem_rd_en, instr_valid, opcode, operand, instr_pc, instr_len2});
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tests++;
            if (c < 3) begin
                if (instr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_latency c%0d: valid %b want 0", c, instr_valid);
                end
            end else if ({instr_valid, opcode, instr_pc} !== {1'b1, 8'h00, 8'(c - 3)}) begin
                fails++;
                $display("FAIL reset_stream c%0d: valid %b op %h pc %h want 1 00 %h",
                         c, instr_valid, opcode, instr_pc, 8'(c - 3));
            end
        end
    endtask

    task automatic test_two_byte();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h03;
        rom[1] = 8'h42;
        pulse_reset();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                tests++;
                if ({instr_valid, opcode, operand, instr_pc, instr_len2} !==
                    {1'b1, 8'h03, 8'h42, 8'h00, 1'b1}) begin
                    fails++;
                    $display("FAIL two_byte: got %b %h %h %h %b want 1 03 42 00 1",
                             instr_valid, opcode, operand, instr_pc, instr_len2);
                end
            end else if (c == 5) begin
                tests++;
                if ({instr_valid, opcode, instr_pc, instr_len2} !== {1'b1, 8'h00, 8'h02, 1'b0}) begin
                    fails++;
                    $display("FAIL two_byte_next: got %b %h %h %b want 1 00 02 0",
                             instr_valid, opcode, instr_pc, instr_len2);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0]  pc;
        logic [25:0] held;
        int          consumed;
        int          issued;
        bit          seen;
        fill_random();
        pulse_reset();
        pc = 8'h00;
        consumed = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                tests++;
                if ({opcode, operand, instr_len2, instr_pc} !== {ref_instr(pc), pc}) begin
                    fails++;
                    $display("FAIL stall_pre: got %h %h %b %h want %h at %h",
                             opcode, operand, instr_len2, instr_pc, ref_instr(pc), pc);
                end
                consumed += ref_len2(rom[pc]) ? 2 : 1;
                pc = pc + (ref_len2(rom[pc]) ? 8'd2 : 8'd1);
                if (c >= 6) seen = 1'b1;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL stall_setup: valid %b want 1 within 20 cycles", instr_valid);
        end
        held = {instr_valid, opcode, operand, instr_pc, instr_len2};
        stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if ({instr_valid, opcode, operand, instr_pc, instr_len2} !== held) begin
                fails++;
                $display("FAIL stall_hold c%0d: got %h want %h", c,
                         {instr_valid, opcode, operand, instr_pc, instr_len2}, held);
            end
        end
        tests++;
        if ({mem_rd_en, reads - consumed} !== {1'b0, 32'(DEPTH)}) begin
            fails++;
            $display("FAIL stall_full: rd_en %b buffered %0d want 0 %0d",
                     mem_rd_en, reads - consumed, DEPTH);
        end
        stall = 1'b0;
        issued = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                tests++;
                if ({opcode, operand, instr_len2, instr_pc} !== {ref_instr(pc), pc}) begin
                    fails++;
                    $display("FAIL stall_resume: got %h %h %b %h want %h at %h",
                             opcode, operand, instr_len2, instr_pc, ref_instr(pc), pc);
                end
                pc = pc + (ref_len2(rom[pc]) ? 8'd2 : 8'd1);
                issued++;
            end
        end
        tests++;
        if (issued < 6) begin
            fails++;
            $display("FAIL stall_progress: issued %0d want >= 6", issued);
        end
    endtask

    task automatic test_redirect();
        logic [7:0] pc;
        logic [7:0] stale_addr;
        bit         found;
        fill_random();
        pulse_reset();
        found = 1'b0;
        stale_addr = 8'h00;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (c >= 6 && mem_rd_en) begin
                found = 1'b1;
                stale_addr = mem_addr;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL redirect_setup: rd_en %b want 1 within 20 cycles", mem_rd_en);
        end
        // Make the killed byte distinguishable from the redirect target
        rom[stale_addr] = 8'hF8;
        rom[8'h80] = 8'h21;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 8'h80;
        #1;
        tests++;
        if (mem_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL redirect_no_read: rd_en %b want 0", mem_rd_en);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            tests++;
            if (c < 4) begin
                if (instr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL redirect_latency c%0d: valid %b want 0", c, instr_valid);
                end
            end else if ({instr_valid, opcode, instr_pc, instr_len2} !==
                         {1'b1, 8'h21, 8'h80, 1'b0}) begin
                fails++;
                $display("FAIL redirect_target: got %b %h %h %b want 1 21 80 0",
                         instr_valid, opcode, instr_pc, instr_len2);
            end
        end
        pc = 8'h81;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                tests++;
                if ({opcode, operand, instr_len2, instr_pc} !== {ref_instr(pc), pc}) begin
                    fails++;
                    $display("FAIL redirect_stream: got %h %h %b %h want %h at %h",
                             opcode, operand, instr_len2, instr_pc, ref_instr(pc), pc);
                end
                pc = pc + (ref_len2(rom[pc]) ? 8'd2 : 8'd1);
            end
        end
    endtask

    task automatic test_wrap();
        rom[8'hFF] = 8'h58;
        rom[8'h00] = 8'h7A;
        rom[8'h01] = 8'h00;
        stall = 1'b0;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            tests++;
            if (c < 5) begin
                if (instr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_latency c%0d: valid %b want 0", c, instr_valid);
                end
            end else if (c == 5) begin
                if ({instr_valid, opcode, operand, instr_pc, instr_len2} !==
                    {1'b1, 8'h58, 8'h7A, 8'hFF, 1'b1}) begin
                    fails++;
                    $display("FAIL wrap_instr: got %b %h %h %h %b want 1 58 7a ff 1",
                             instr_valid, opcode, operand, instr_pc, instr_len2);
                end
            end else if ({instr_valid, opcode, instr_pc, instr_len2} !==
                         {1'b1, 8'h00, 8'h01, 1'b0}) begin
                fails++;
                $display("FAIL wrap_next: got %b %h %h %b want 1 00 01 0",
                         instr_valid, opcode, instr_pc, instr_len2);
            end
        end
    endtask

    task automatic test_len_sweep();
        logic [7:0] op;
        bit         l2;
        int         got_cyc;
        stall = 1'b0;
        for (int k = 0; k < 256; k++) begin
            op = 8'(k);
            l2 = ref_len2(op);
            rom[8'h10] = op;
            rom[8'h11] = 8'($urandom);
            @(negedge clk);
            redirect = 1'b1;
            redirect_pc = 8'h10;
            got_cyc = 0;
            for (int c = 1; c <= 8 && got_cyc == 0; c++) begin
                @(negedge clk);
                redirect = 1'b0;
                if (instr_valid) got_cyc = c;
            end
            tests++;
            if ({got_cyc, instr_pc, opcode, operand, instr_len2} !==
                {4 + int'(l2), 8'h10, op, l2 ? rom[8'h11] : 8'h00, l2}) begin
                fails++;
                $display("FAIL len_sweep op %h: cyc %0d pc %h op %h opnd %h len2 %b want cyc %0d len2 %b",
                         op, got_cyc, instr_pc, opcode, operand, instr_len2, 4 + int'(l2), l2);
            end
        end
    endtask

    task automatic test_async_reset_mid_stall();
        bit seen;
        fill_random();
        pulse_reset();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (c >= 4 && instr_valid) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL async_setup: valid %b want 1 within 20 cycles", instr_valid);
        end
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({mem_rd_en, instr_valid, opcode, operand, instr_pc, instr_len2} !== 27'd0) begin
            fails++;
            $display("FAIL async_reset: got %h want 0",
                     {mem_rd_en, instr_valid, opcode, operand, instr_pc, instr_len2});
        end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [7:0]  pc;
        logic [25:0] held;
        bit          hold;
        int          issued;
        fill_random();
        pulse_reset();
        pc = 8'h00;
        hold = 1'b0;
        held = '0;
        issued = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (hold) begin
                tests++;
                if ({instr_valid, opcode, operand, instr_pc, instr_len2} !== held) begin
                    fails++;
                    $display("FAIL rand_hold c%0d: got %h want %h", c,
                             {instr_valid, opcode, operand, instr_pc, instr_len2}, held);
                end
            end else if (instr_valid) begin
                tests++;
                if ({opcode, operand, instr_len2, instr_pc} !== {ref_instr(pc), pc}) begin
                    fails++;
                    $display("FAIL rand_instr c%0d: got %h %h %b %h want %h at %h", c,
                             opcode, operand, instr_len2, instr_pc, ref_instr(pc), pc);
                end
                pc = pc + (ref_len2(rom[pc]) ? 8'd2 : 8'd1);
                issued++;
            end
            redirect = 1'b0;
            if ($urandom_range(99) < 4) begin
                redirect = 1'b1;
                redirect_pc = 8'($urandom);
                pc = redirect_pc;
                hold = 1'b0;
                stall = 1'($urandom_range(1));
            end else begin
                stall = ($urandom_range(99) < 30);
                hold = instr_valid && stall;
                held = {instr_valid, opcode, operand, instr_pc, instr_len2};
            end
        end
        redirect = 1'b0;
        stall = 1'b0;
        tests++;
        if (issued < 50) begin
            fails++;
            $display("FAIL rand_progress: issued %0d want >= 50", issued);
        end
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_stall();
        test_redirect();
        test_wrap();
        test_len_sweep();
        test_async_reset_mid_stall();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
